// File: rtl/mul6x6_accum.sv
// Accumulates a stream of 12-bit products into an ACC_W-bit sum with beat count and sticky carry flag.
// Result is presented in DONE and held until out_ready; in_ready is low while a result waits.
module mul6x6_accum #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      in_p,
  input  logic             in_last,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [ACC_W-1:0] r_acc;
  logic [7:0]       r_count;
  logic             r_ovf;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic [ACC_W:0]   w_sum;

  assign w_accept = in_valid & w_in_ready;
  // One extra bit captures the carry out of the accumulator width.
  assign w_sum    = {1'b0, r_acc} + (ACC_W+1)'(in_p);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_ACC: begin
        if (w_accept) begin
          w_next = in_last ? S_DONE : S_ACC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b1;
    w_out_valid = 1'b0;
    if (r_state == S_DONE) begin
      w_in_ready  = 1'b0;
      w_out_valid = 1'b1;
    end
  end

  // clr outranks a beat accepted in the same cycle; that beat is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_count <= 8'd0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_acc   <= '0;
      r_count <= 8'd0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      if (r_state == S_IDLE) begin
        r_acc   <= ACC_W'(in_p);
        r_count <= 8'd1;
        r_ovf   <= 1'b0;
      end else begin
        r_acc   <= w_sum[ACC_W-1:0];
        r_ovf   <= r_ovf | w_sum[ACC_W];
        r_count <= (r_count == 8'd255) ? 8'd255 : r_count + 8'd1;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_sum   = r_acc;
  assign out_count = r_count;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_mul6x6_accum.sv
// Directed bench for mul6x6_accum: table of whole accumulations plus hand-written
// sequences for back-pressure, clr, gaps and asynchronous reset.
module tb_mul6x6_accum;

  localparam int ACC_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [11:0]      in_p;
  logic             in_last;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [7:0]       out_count;
  logic             out_ovf;

  int n_checks = 0;
  int n_errors = 0;

  mul6x6_accum #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .in_last   (in_last),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    string       name;
    int          n;
    logic [11:0] p;
    logic [15:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] p, input logic last);
    in_valid = 1'b1;
    in_p     = p;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [15:0] hold_sum;
  logic [7:0]  hold_cnt;

  initial begin
    vecs[0] = '{"single_3969",   1, 12'd3969, 16'd3969,  8'd1,   1'b0};
    vecs[1] = '{"sixteen_3969", 16, 12'd3969, 16'd63504, 8'd16,  1'b0};
    vecs[2] = '{"seventeen",    17, 12'd3969, 16'd1937,  8'd17,  1'b1};
    vecs[3] = '{"single_zero",   1, 12'd0,    16'd0,     8'd1,   1'b0};
    vecs[4] = '{"single_max",    1, 12'd4095, 16'd4095,  8'd1,   1'b0};
    vecs[5] = '{"three_100",     3, 12'd100,  16'd300,   8'd3,   1'b0};
    vecs[6] = '{"sat_ones",    300, 12'd1,    16'd300,   8'd255, 1'b0};
    vecs[7] = '{"sat_max",     300, 12'd4095, 16'd48852, 8'd255, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_p = '0; in_last = 1'b0; clr = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_in_ready_async", 32'(in_ready), 32'd1);
    check("rst_out_valid_async", 32'(out_valid), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        send(vecs[v].p, (i == vecs[v].n - 1));
        if (i != vecs[v].n - 1 && !out_valid === 1'b0) begin
          check({vecs[v].name, "_early_valid"}, 32'(out_valid), 32'd0);
        end
      end
      check({vecs[v].name, "_valid"}, 32'(out_valid), 32'd1);
      check({vecs[v].name, "_in_ready"}, 32'(in_ready), 32'd0);
      check({vecs[v].name, "_sum"}, 32'(out_sum), 32'(vecs[v].sum));
      check({vecs[v].name, "_count"}, 32'(out_count), 32'(vecs[v].cnt));
      check({vecs[v].name, "_ovf"}, 32'(out_ovf), 32'(vecs[v].ovf));
      take();
      check({vecs[v].name, "_idle_valid"}, 32'(out_valid), 32'd0);
      check({vecs[v].name, "_idle_ready"}, 32'(in_ready), 32'd1);
    end

    // Gaps in ACC hold the partial result.
    send(12'd10, 1'b0);
    tick(); tick(); tick();
    check("gap_hold_sum", 32'(out_sum), 32'd10);
    check("gap_hold_count", 32'(out_count), 32'd1);
    send(12'd20, 1'b1);
    check("gap_sum", 32'(out_sum), 32'd30);
    check("gap_count", 32'(out_count), 32'd2);

    // Back-pressure in DONE with a beat offered every cycle.
    in_valid = 1'b1; in_p = 12'd999; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(out_sum), 32'd30);
      check("bp_count", 32'(out_count), 32'd2);
    end
    in_valid = 1'b0; in_last = 1'b0;
    take();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    send(12'd5, 1'b1);
    check("bp_fresh_sum", 32'(out_sum), 32'd5);
    check("bp_fresh_count", 32'(out_count), 32'd1);
    take();

    // clr mid-accumulation discards the concurrent beat.
    send(12'd100, 1'b0);
    send(12'd200, 1'b0);
    check("clr_pre_sum", 32'(out_sum), 32'd300);
    clr = 1'b1; in_valid = 1'b1; in_p = 12'd50;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    check("clr_sum", 32'(out_sum), 32'd0);
    check("clr_count", 32'(out_count), 32'd0);
    check("clr_valid", 32'(out_valid), 32'd0);
    check("clr_in_ready", 32'(in_ready), 32'd1);
    send(12'd7, 1'b1);
    check("clr_after_sum", 32'(out_sum), 32'd7);
    check("clr_after_count", 32'(out_count), 32'd1);

    // clr in DONE outranks out_ready and empties the result.
    clr = 1'b1; out_ready = 1'b1;
    tick();
    clr = 1'b0; out_ready = 1'b0;
    check("clr_done_valid", 32'(out_valid), 32'd0);
    check("clr_done_count", 32'(out_count), 32'd0);

    // Asynchronous reset while a result waits.
    send(12'd3969, 1'b1);
    check("arst_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid_drop", 32'(out_valid), 32'd0);
    check("arst_sum_zero", 32'(out_sum), 32'd0);
    #1;
    rst = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("arst_count", 32'(out_count), 32'd0);
    send(12'd42, 1'b1);
    check("arst_fresh_sum", 32'(out_sum), 32'd42);
    hold_sum = out_sum;
    hold_cnt = out_count;
    check("arst_fresh_count", 32'(hold_cnt), 32'd1);
    take();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
